mips_data_mem: RTL and testbench
================================

Name: mips_data_mem

Overview:
- Data-memory responder for the pipelined MIPS core.
- Services the core's load/store port: byte-lane writes, loads returned one cycle after the request, freeze on `en` low.
- Also decodes a small memory-mapped register window: cycle counter, output register, test-done/result and status. Benches and the board wrapper use these to observe program progress.
- Sits beside the core in the top level, wired directly to its memory port.

Parameters:
- ADDR_WIDTH, 10, word-address bits of the RAM array (2^ADDR_WIDTH 32-bit words; default 4 KB).
- MMIO_BASE, 32'hFFFF_0000, byte base of the 16-byte register window.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; when low, no state changes.
- mem_write_en  input  4  byte-lane write enables; bit3 = data[31:24] = byte offset 0, bit0 = data[7:0] = offset 3.
- mem_read_en  input  1  load request this cycle.
- mem_addr  input  32  byte address; bits[1:0] ignored for word selection.
- mem_write_data  input  32  store data; the core replicates byte stores into all lanes.
- mem_read_data  output  32  registered load data, valid the cycle after the request.
- out_reg  output  32  value of the OUT register.
- test_done  output  1  sticky; set by a DONE write.
- test_code  output  32  data of the first DONE write.
- bus_err  output  1  sticky; access to an unmapped address.

Behaviour:
Reset (rst=1 at an edge):
- mem_read_data, out_reg, test_code and the cycle counter clear to 0.
- test_done and bus_err clear to 0.
- RAM contents are not cleared.
- rst has priority over en.

Freeze:
- With en=0, RAM, all registers and mem_read_data hold.
- The core stalls by dropping en, so the returned data must persist across the stall.

Decode (on the word address mem_addr[31:2]):
- RAM hit: mem_addr[31:ADDR_WIDTH+2]==0. Index is mem_addr[ADDR_WIDTH+1:2].
- MMIO hit: mem_addr[31:4]==MMIO_BASE[31:4]. Register select is mem_addr[3:2].
- Anything else is unmapped.

Writes (en=1, any mem_write_en bit set):
- RAM: write only the enabled lanes; other lanes unchanged.
- MMIO +0x0 CYCLE: read-only; write ignored, no error.
- MMIO +0x4 OUT: byte lanes honoured.
- MMIO +0x8 DONE: any write sets test_done=1. test_code takes the full mem_write_data, but only if test_done was 0; later DONE writes do not change test_code.
- MMIO +0xC STATUS: read-only; write ignored.
- Unmapped: write dropped, bus_err<=1.

Reads (en=1, mem_read_en=1):
- mem_read_data loads on that edge:
  - RAM word, or
  - CYCLE (pre-increment value), OUT, test_code, or STATUS = {30'b0, bus_err, test_done}.
- Unmapped read returns 32'h0 and sets bus_err.
- When mem_read_en=0 with en=1, mem_read_data holds its previous value (not cleared).
- Latency is exactly 1 cycle; no back-pressure, every request completes.

Simultaneous read and write, same address:
- The write is performed.
- The read returns pre-write data.
- Each access checks bus_err independently.

Cycle counter:
- Increments by 1 each edge with en=1 and rst=0.
- Wraps 32'hFFFF_FFFF -> 0.
- Unaffected by writes.

STATUS read in the same cycle as a flag-setting access returns the pre-update flags.

Test Plan:
- Reset with en=1, then word store 0xDEADBEEF to 0x10 (we=4'b1111) and load 0x10 next cycle -> mem_read_data=0xDEADBEEF exactly one cycle after the load; 0 before the load.
- Store 0x11223344 to 0x20, then byte store 0xAA (replicated 0xAAAAAAAA) at 0x21 with we=4'b0100 -> load 0x20 returns 0x11AA3344.
- Load 0x10 (holding 0xDEADBEEF), drop en for 3 cycles while toggling address/we -> mem_read_data stays 0xDEADBEEF, RAM and counter unchanged; counter resumes +1 per cycle when en returns.
- Write 0x5 to MMIO_BASE+8, then 0x9 to MMIO_BASE+8 -> test_done=1, test_code=0x5. Load MMIO_BASE+0xC -> 0x1.
- Load from 0x0001_0000 (unmapped, ADDR_WIDTH=10) -> mem_read_data=0, bus_err=1, STATUS reads 0x2 (test_done=0). A following synchronous rst clears bus_err.
- Preload cycle counter near wrap (force 0xFFFF_FFFE), run 3 enabled cycles -> counter 0x0000_0001. Load of MMIO_BASE+0 returns its value at the request edge.

Source files
------------

// File: rtl/mips_data_mem.sv
// Data-memory responder for the pipelined MIPS core: byte-lane RAM with 1-cycle registered loads,
// plus a 16-byte MMIO window (CYCLE, OUT, DONE/test_code, STATUS) used to observe program progress.
module mips_data_mem #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  mem_write_en,
  input  logic        mem_read_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic [31:0] out_reg,
  output logic        test_done,
  output logic [31:0] test_code,
  output logic        bus_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           ram_q [DEPTH];
  logic [31:0]           ram_rd_q;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [1:0]            reg_sel;
  logic                  ram_hit, mmio_hit, unmapped;
  logic                  do_write, do_read;
  logic [31:0]           lane_mask;
  logic [31:0]           mmio_rdata;
  logic                  unused_addr_bits;

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] out_q, out_d;
  logic        done_q, done_d;
  logic [31:0] code_q, code_d;
  logic        err_q, err_d;
  logic [31:0] rd_mmio_q, rd_mmio_d;
  logic        rd_sel_ram_q, rd_sel_ram_d;

  assign ram_idx          = mem_addr[ADDR_WIDTH+1:2];
  assign reg_sel          = mem_addr[3:2];
  assign ram_hit          = (mem_addr[31:ADDR_WIDTH+2] == '0);
  assign mmio_hit         = (mem_addr[31:4] == MMIO_BASE[31:4]);
  assign unmapped         = !ram_hit && !mmio_hit;
  assign do_write         = en && (|mem_write_en);
  assign do_read          = en && mem_read_en;
  assign unused_addr_bits = ^mem_addr[1:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
    assign lane_mask[8*gi +: 8] = {8{mem_write_en[gi]}};
  end

  // RAM with byte enables and a registered read port; NBA ordering gives read-before-write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_write && ram_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_write_en[b]) ram_q[ram_idx][8*b +: 8] <= mem_write_data[8*b +: 8];
        end
      end
      if (do_read && ram_hit) ram_rd_q <= ram_q[ram_idx];
    end
  end

  always_comb begin
    unique case (reg_sel)
      2'd0:    mmio_rdata = cycle_q;
      2'd1:    mmio_rdata = out_q;
      2'd2:    mmio_rdata = code_q;
      default: mmio_rdata = {30'b0, err_q, done_q};
    endcase
  end

  always_comb begin
    cycle_d      = en ? cycle_q + 32'd1 : cycle_q;
    out_d        = out_q;
    done_d       = done_q;
    code_d       = code_q;
    err_d        = err_q;
    rd_mmio_d    = rd_mmio_q;
    rd_sel_ram_d = rd_sel_ram_q;

    if (do_write && mmio_hit && reg_sel == 2'd1)
      out_d = (out_q & ~lane_mask) | (mem_write_data & lane_mask);
    // Only the first DONE write records a code; later ones just keep the flag set.
    if (do_write && mmio_hit && reg_sel == 2'd2) begin
      done_d = 1'b1;
      if (!done_q) code_d = mem_write_data;
    end
    if (unmapped && (do_write || do_read)) err_d = 1'b1;

    if (do_read) begin
      rd_sel_ram_d = ram_hit;
      rd_mmio_d    = mmio_hit ? mmio_rdata : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q      <= 32'h0;
      out_q        <= 32'h0;
      done_q       <= 1'b0;
      code_q       <= 32'h0;
      err_q        <= 1'b0;
      rd_mmio_q    <= 32'h0;
      rd_sel_ram_q <= 1'b0;
    end else begin
      cycle_q      <= cycle_d;
      out_q        <= out_d;
      done_q       <= done_d;
      code_q       <= code_d;
      err_q        <= err_d;
      rd_mmio_q    <= rd_mmio_d;
      rd_sel_ram_q <= rd_sel_ram_d;
    end
  end

  assign mem_read_data = rd_sel_ram_q ? ram_rd_q : rd_mmio_q;
  assign out_reg       = out_q;
  assign test_done     = done_q;
  assign test_code     = code_q;
  assign bus_err       = err_q;

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed bench for mips_data_mem: a byte-level memory/register model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mips_data_mem;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [3:0]  mem_write_en = 4'h0;
  logic        mem_read_en = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_write_data = 32'h0;
  logic [31:0] mem_read_data, out_reg, test_code;
  logic        test_done, bus_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  mips_data_mem #(.ADDR_WIDTH(10), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .en(en),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .out_reg(out_reg),
    .test_done(test_done), .test_code(test_code), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: byte-addressed RAM, MMIO registers as plain variables.
  logic [7:0]  m_bytes [int];
  logic [31:0] m_cyc, m_out, m_code, m_rdata;
  bit          m_done, m_err;

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      int ba;
      ba = int'({a[31:2], 2'b00}) + k;
      if (m_bytes.exists(ba)) w[31-8*k -: 8] = m_bytes[ba];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_rdata = 0; m_out = 0; m_code = 0; m_cyc = 0; m_done = 0; m_err = 0;
    end else if (en) begin
      logic is_ram, is_mmio;
      logic [31:0] off;
      bit new_err;
      is_ram  = (mem_addr < 32'd4096);
      is_mmio = (mem_addr >= BASE) && (mem_addr - BASE < 32'd16);
      off     = mem_addr - BASE;
      new_err = m_err;
      if (mem_read_en) begin
        if (is_ram) m_rdata = m_word(mem_addr);
        else if (is_mmio) begin
          case (off / 4)
            0: m_rdata = m_cyc;
            1: m_rdata = m_out;
            2: m_rdata = m_code;
            default: m_rdata = {30'b0, m_err, m_done};
          endcase
        end else begin
          m_rdata = 0;
          new_err = 1;
        end
      end
      if (mem_write_en != 0) begin
        if (is_ram) begin
          for (int k = 0; k < 4; k++)
            if (mem_write_en[3-k])
              m_bytes[int'({mem_addr[31:2], 2'b00}) + k] = mem_write_data[31-8*k -: 8];
        end else if (is_mmio) begin
          if (off / 4 == 1) begin
            for (int k = 0; k < 4; k++)
              if (mem_write_en[3-k]) m_out[31-8*k -: 8] = mem_write_data[31-8*k -: 8];
          end else if (off / 4 == 2) begin
            if (!m_done) m_code = mem_write_data;
            m_done = 1;
          end
        end else new_err = 1;
      end
      m_err = new_err;
      m_cyc = m_cyc + 1;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("rdata", mem_read_data, m_rdata);
      cmp("out_reg", out_reg, m_out);
      cmp("test_done", {31'b0, test_done}, {31'b0, m_done});
      cmp("test_code", test_code, m_code);
      cmp("bus_err", {31'b0, bus_err}, {31'b0, m_err});
      $display("cyc t=%0t rst=%0b en=%0b we=%h re=%0b a=%08h d=%08h -> rdata=%08h err=%0b",
               $time, rst, en, mem_write_en, mem_read_en, mem_addr, mem_write_data,
               mem_read_data, bus_err);
    end
  end

  task automatic step(input bit r, input bit e, input logic [3:0] we, input bit re,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; en = e; mem_write_en = we; mem_read_en = re; mem_addr = a; mem_write_data = d;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1, 1, 4'h0, 0, 32'h0, 32'h0);
    after_edge();
    chk_on = 1'b1;
    cmp("lit_reset_rdata", mem_read_data, 32'h0);
    cmp("lit_reset_err", {31'b0, bus_err}, 32'h0);

    // Store then load; data appears exactly one cycle after the load.
    step(0, 1, 4'hF, 0, 32'h10, 32'hDEAD_BEEF);
    after_edge();
    cmp("lit_before_load", mem_read_data, 32'h0);
    step(0, 1, 4'h0, 1, 32'h10, 32'h0);
    after_edge();
    cmp("lit_load_10", mem_read_data, 32'hDEAD_BEEF);

    // Byte lane merge.
    step(0, 1, 4'hF, 0, 32'h20, 32'h1122_3344);
    step(0, 1, 4'h4, 0, 32'h21, 32'hAAAA_AAAA);
    step(0, 1, 4'h0, 1, 32'h20, 32'h0);
    after_edge();
    cmp("lit_byte_merge", mem_read_data, 32'h11AA_3344);

    // Freeze: data, RAM and counter hold while en is low.
    step(0, 1, 4'h0, 1, 32'h10, 32'h0);
    step(0, 0, 4'hF, 1, 32'h10, 32'h0);
    step(0, 0, 4'h0, 1, BASE + 4, 32'h5);
    step(0, 0, 4'hF, 1, 32'h20, 32'h7);
    after_edge();
    cmp("lit_freeze_hold", mem_read_data, 32'hDEAD_BEEF);
    step(0, 1, 4'h0, 1, 32'h10, 32'h0);
    step(0, 1, 4'h0, 1, BASE, 32'h0);
    step(0, 1, 4'h0, 1, BASE, 32'h0);
    step(0, 1, 4'h0, 0, 32'h20, 32'h0);
    step(0, 1, 4'h0, 0, 32'h20, 32'h0);

    // OUT with byte lanes, DONE stickiness, STATUS.
    step(0, 1, 4'hF, 0, BASE + 4, 32'h1234_5678);
    step(0, 1, 4'h1, 0, BASE + 4, 32'hFFFF_FFFF);
    after_edge();
    cmp("lit_out_lane", out_reg, 32'h1234_56FF);
    step(0, 1, 4'hF, 0, BASE + 8, 32'h5);
    step(0, 1, 4'hF, 0, BASE + 8, 32'h9);
    step(0, 1, 4'h0, 1, BASE + 12, 32'h0);
    after_edge();
    cmp("lit_done", {31'b0, test_done}, 32'h1);
    cmp("lit_code", test_code, 32'h5);
    cmp("lit_status", mem_read_data, 32'h1);
    step(0, 1, 4'hF, 1, BASE, 32'h0);
    step(0, 1, 4'hF, 1, BASE + 12, 32'h0);

    // Same-address read/write returns pre-write data.
    step(0, 1, 4'hF, 0, 32'h30, 32'h1);
    step(0, 1, 4'hF, 1, 32'h30, 32'h2);
    after_edge();
    cmp("lit_rw_old", mem_read_data, 32'h1);
    step(0, 1, 4'h0, 1, 32'h30, 32'h0);

    // Unmapped accesses and reset.
    step(1, 1, 4'h0, 0, 32'h0, 32'h0);
    step(0, 1, 4'h0, 1, 32'h0001_0000, 32'h0);
    after_edge();
    cmp("lit_unmapped_rdata", mem_read_data, 32'h0);
    cmp("lit_unmapped_err", {31'b0, bus_err}, 32'h1);
    step(0, 1, 4'h0, 1, BASE + 12, 32'h0);
    after_edge();
    cmp("lit_status_err", mem_read_data, 32'h2);
    step(1, 0, 4'h0, 0, 32'h0, 32'h0);
    after_edge();
    cmp("lit_rst_clears_err", {31'b0, bus_err}, 32'h0);
    step(0, 1, 4'hF, 0, 32'h8000_0000, 32'h3);
    step(0, 1, 4'hF, 1, BASE + 8, 32'h77);
    step(0, 1, 4'h0, 1, BASE + 12, 32'h0);
    after_edge();
    cmp("lit_status_both", mem_read_data, 32'h3);

    // Counter wrap from a preloaded value.
    step(0, 0, 4'h0, 0, BASE, 32'h0);
    force dut.cycle_q = 32'hFFFF_FFFE;
    m_cyc = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cycle_q;
    step(0, 1, 4'h0, 1, BASE, 32'h0);
    after_edge();
    cmp("lit_cyc_fffe", mem_read_data, 32'hFFFF_FFFE);
    step(0, 1, 4'h0, 1, BASE, 32'h0);
    step(0, 1, 4'h0, 1, BASE, 32'h0);
    after_edge();
    cmp("lit_cyc_wrap", mem_read_data, 32'h0);
    step(0, 1, 4'h0, 1, BASE, 32'h0);
    after_edge();
    cmp("lit_cyc_one", mem_read_data, 32'h1);
    step(0, 1, 4'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
